// File: rtl/shreg_arb_pkg.sv
// Shared types for the two-requester shift-register arbiter: controller states and the stage record.
// The stage record here is the default-width form; the top builds the same layout at its own WIDTH.
package shreg_arb_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        FLUSH  = 2'd2
    } state_t;

    typedef struct packed {
        logic [DEFAULT_WIDTH-1:0] data;
        logic                     src;
        logic                     valid;
    } stage_t;

endpackage

// File: rtl/shreg_arb_ctrl_if.sv
// Request/response bundle between the two requesters, the consumer and shreg_arb_ctrl.
// Defining SHREG_ARB_STATS_EN adds the per-requester accept counters Acc0/Acc1.
interface shreg_arb_ctrl_if #(
    parameter int WIDTH = 16
);

    logic [WIDTH-1:0] Din0;
    logic             Valid0;
    logic             Ready0;
    logic [WIDTH-1:0] Din1;
    logic             Valid1;
    logic             Ready1;
    logic             Flush;
    logic [WIDTH-1:0] Dout;
    logic             Src;
    logic             OutValid;
    logic             OutReady;
    logic [3:0]       Count;
    logic             Busy;

`ifdef SHREG_ARB_STATS_EN
    logic [15:0]      Acc0;
    logic [15:0]      Acc1;

    modport master (
        output Din0, Valid0, Din1, Valid1, Flush, OutReady,
        input  Ready0, Ready1, Dout, Src, OutValid, Count, Busy, Acc0, Acc1
    );

    modport slave (
        input  Din0, Valid0, Din1, Valid1, Flush, OutReady,
        output Ready0, Ready1, Dout, Src, OutValid, Count, Busy, Acc0, Acc1
    );
`else
    modport master (
        output Din0, Valid0, Din1, Valid1, Flush, OutReady,
        input  Ready0, Ready1, Dout, Src, OutValid, Count, Busy
    );

    modport slave (
        input  Din0, Valid0, Din1, Valid1, Flush, OutReady,
        output Ready0, Ready1, Dout, Src, OutValid, Count, Busy
    );
`endif

endinterface

// File: rtl/shreg_stage.sv
// One enabled pipeline register holding a stage record; the record layout is passed in as a type.
module shreg_stage
    import shreg_arb_pkg::*;
#(
    parameter type T = stage_t
) (
    input  logic Clock,
    input  logic Reset,
    input  logic i_en,
    input  T     i_d,
    output T     o_q
);

    T r_q;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/shreg_arb_ctrl.sv
// Round-robin arbiter for two requesters feeding a DEPTH-stage shift chain with flush and occupancy count.
// Optional feature: define SHREG_ARB_STATS_EN for saturating per-requester accept counters.
module shreg_arb_ctrl
    import shreg_arb_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input logic               Clock,
    input logic               Reset,
    shreg_arb_ctrl_if.slave   bus
);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             src;
        logic             valid;
    } stage_w_t;

    stage_w_t   w_stage_q [DEPTH];
    stage_w_t   w_head_d;

    state_t     r_state;
    logic       r_busy;
    logic       r_last;
    logic [3:0] r_count;

    logic       w_advance;
    logic       w_open;
    logic       w_grant0;
    logic       w_grant1;
    logic       w_ready0;
    logic       w_ready1;
    logic       w_accept;
    logic       w_consume;
    logic [3:0] w_count_next;

    // r_last names the requester accepted most recently; a tie goes to the other one.
    assign w_advance    = !w_stage_q[DEPTH-1].valid || bus.OutReady;
    assign w_open       = w_advance && !bus.Flush && (r_state != FLUSH);
    assign w_grant0     = bus.Valid0 && (!bus.Valid1 || r_last);
    assign w_grant1     = bus.Valid1 && (!bus.Valid0 || !r_last);
    assign w_ready0     = w_open && w_grant0;
    assign w_ready1     = w_open && w_grant1;
    assign w_accept     = w_ready0 || w_ready1;
    assign w_consume    = w_stage_q[DEPTH-1].valid && bus.OutReady;
    assign w_count_next = r_count + {3'b000, w_accept} - {3'b000, w_consume};

    // A cycle without an accept pushes a bubble that keeps the old data and tag.
    always_comb begin
        w_head_d       = w_stage_q[0];
        w_head_d.valid = 1'b0;
        if (w_ready1) begin
            w_head_d.data  = bus.Din1;
            w_head_d.src   = 1'b1;
            w_head_d.valid = 1'b1;
        end else if (w_ready0) begin
            w_head_d.data  = bus.Din0;
            w_head_d.src   = 1'b0;
            w_head_d.valid = 1'b1;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        if (i == 0) begin : g_head
            shreg_stage #(.T(stage_w_t)) u_stage (
                .Clock (Clock),
                .Reset (Reset),
                .i_en  (w_advance),
                .i_d   (w_head_d),
                .o_q   (w_stage_q[i])
            );
        end else begin : g_body
            shreg_stage #(.T(stage_w_t)) u_stage (
                .Clock (Clock),
                .Reset (Reset),
                .i_en  (w_advance),
                .i_d   (w_stage_q[i-1]),
                .o_q   (w_stage_q[i])
            );
        end
    end

    // Returning to IDLE is decided on the next occupancy so Busy drops with the last consume.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_last  <= 1'b1;
            r_count <= 4'd0;
        end else begin
            r_count <= w_count_next;
            if (w_accept) begin
                r_last <= w_ready1;
            end
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state <= ACTIVE;
                        r_busy  <= 1'b1;
                    end
                end
                ACTIVE: begin
                    if (w_count_next == 4'd0) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else if (bus.Flush) begin
                        r_state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (w_count_next == 4'd0) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef SHREG_ARB_STATS_EN
    logic [15:0] r_acc0;
    logic [15:0] r_acc1;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_acc0 <= 16'd0;
            r_acc1 <= 16'd0;
        end else begin
            if (w_ready0 && (r_acc0 != 16'hFFFF)) begin
                r_acc0 <= r_acc0 + 16'd1;
            end
            if (w_ready1 && (r_acc1 != 16'hFFFF)) begin
                r_acc1 <= r_acc1 + 16'd1;
            end
        end
    end

    assign bus.Acc0 = r_acc0;
    assign bus.Acc1 = r_acc1;
`endif

    assign bus.Ready0   = w_ready0;
    assign bus.Ready1   = w_ready1;
    assign bus.Dout     = w_stage_q[DEPTH-1].data;
    assign bus.Src      = w_stage_q[DEPTH-1].src;
    assign bus.OutValid = w_stage_q[DEPTH-1].valid;
    assign bus.Count    = r_count;
    assign bus.Busy     = r_busy;

endmodule

// File: tb/tb_shreg_arb_ctrl.sv
// Directed bench for shreg_arb_ctrl (WIDTH 16, DEPTH 8); stats checks run only with SHREG_ARB_STATS_EN.
module tb_shreg_arb_ctrl;

    logic Clock = 1'b0;
    logic Reset = 1'b0;
    int   assertCount = 0;
    int   failCount   = 0;

    shreg_arb_ctrl_if #(.WIDTH(16)) bus ();

    shreg_arb_ctrl #(.WIDTH(16), .DEPTH(8)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clock = ~Clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic applyStimulus(input logic v0, input logic [15:0] d0, input logic v1, input logic [15:0] d1,
                                 input logic outReady, input logic flush);
        bus.Valid0   = v0;
        bus.Din0     = d0;
        bus.Valid1   = v1;
        bus.Din1     = d1;
        bus.OutReady = outReady;
        bus.Flush    = flush;
        #1;
    endtask

    task automatic resetDut();
        applyStimulus(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0);
        Reset = 1'b0;
        #2;
        Reset = 1'b1;
        tick();
    endtask

    logic [15:0] k0;
    logic [15:0] k1;
    logic [15:0] expData [4];
    int          nOut;
    int          seen;
    logic        done;

    initial begin
        applyStimulus(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0);
        #1;
        checkOutput("reset dout", 32'(bus.Dout), 32'h0);
        checkOutput("reset outvalid", 32'(bus.OutValid), 32'h0);
        checkOutput("reset count", 32'(bus.Count), 32'h0);
        checkOutput("reset busy", 32'(bus.Busy), 32'h0);
        Reset = 1'b1;
        tick();

        // Single word through the chain with the consumer always ready.
        applyStimulus(1'b1, 16'h0008, 1'b0, 16'h0, 1'b1, 1'b0);
        checkOutput("single ready0", 32'(bus.Ready0), 32'h1);
        tick();
        applyStimulus(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0);
        checkOutput("single count after accept", 32'(bus.Count), 32'h1);
        checkOutput("single busy", 32'(bus.Busy), 32'h1);
        repeat (6) tick();
        checkOutput("single outvalid early", 32'(bus.OutValid), 32'h0);
        tick();
        checkOutput("single outvalid", 32'(bus.OutValid), 32'h1);
        checkOutput("single dout", 32'(bus.Dout), 32'h0008);
        checkOutput("single src", 32'(bus.Src), 32'h0);
        checkOutput("single count held", 32'(bus.Count), 32'h1);
        tick();
        checkOutput("single outvalid gone", 32'(bus.OutValid), 32'h0);
        checkOutput("single count drained", 32'(bus.Count), 32'h0);
        checkOutput("single busy low", 32'(bus.Busy), 32'h0);

        // Both requesters contending: grants alternate starting with requester 0.
        resetDut();
        k0 = 16'h0;
        k1 = 16'h0;
        for (int c = 0; c < 4; c++) begin
            applyStimulus(1'b1, 16'hA000 + k0, 1'b1, 16'hB000 + k1, 1'b1, 1'b0);
            checkOutput($sformatf("rr ready0 c%0d", c), 32'(bus.Ready0), (c % 2 == 0) ? 32'h1 : 32'h0);
            checkOutput($sformatf("rr ready1 c%0d", c), 32'(bus.Ready1), (c % 2 == 1) ? 32'h1 : 32'h0);
            if (c % 2 == 0) k0 = k0 + 16'h1;
            else            k1 = k1 + 16'h1;
            tick();
        end
        applyStimulus(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0);
        expData = '{16'hA000, 16'hB000, 16'hA001, 16'hB001};
        repeat (4) tick();
        for (int j = 0; j < 4; j++) begin
            checkOutput($sformatf("rr outvalid %0d", j), 32'(bus.OutValid), 32'h1);
            checkOutput($sformatf("rr dout %0d", j), 32'(bus.Dout), 32'(expData[j]));
            checkOutput($sformatf("rr src %0d", j), 32'(bus.Src), (j % 2 == 1) ? 32'h1 : 32'h0);
            tick();
        end

        // Full chain stalled by the consumer, then one simultaneous consume and accept.
        resetDut();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 16'h1000 + 16'(i), 1'b0, 16'h0, 1'b0, 1'b0);
            checkOutput($sformatf("fill ready0 %0d", i), 32'(bus.Ready0), 32'h1);
            tick();
        end
        applyStimulus(1'b1, 16'h1008, 1'b1, 16'hB123, 1'b0, 1'b0);
        checkOutput("full count", 32'(bus.Count), 32'h8);
        checkOutput("full outvalid", 32'(bus.OutValid), 32'h1);
        checkOutput("full ready0", 32'(bus.Ready0), 32'h0);
        checkOutput("full ready1", 32'(bus.Ready1), 32'h0);
        checkOutput("full dout", 32'(bus.Dout), 32'h1000);
        tick();
        checkOutput("stall count", 32'(bus.Count), 32'h8);
        checkOutput("stall dout", 32'(bus.Dout), 32'h1000);
        applyStimulus(1'b1, 16'h1008, 1'b1, 16'hB123, 1'b1, 1'b0);
        checkOutput("swap ready1", 32'(bus.Ready1), 32'h1);
        checkOutput("swap ready0", 32'(bus.Ready0), 32'h0);
        tick();
        applyStimulus(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
        checkOutput("swap count", 32'(bus.Count), 32'h8);
        checkOutput("swap next dout", 32'(bus.Dout), 32'h1001);
        checkOutput("swap outvalid", 32'(bus.OutValid), 32'h1);

        // Flush with three words in flight while requester 1 keeps asking.
        resetDut();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 16'h3000 + 16'(i), 1'b0, 16'h0, 1'b1, 1'b0);
            tick();
        end
        applyStimulus(1'b0, 16'h0, 1'b1, 16'hB777, 1'b1, 1'b1);
        checkOutput("flush count", 32'(bus.Count), 32'h3);
        checkOutput("flush pulse ready1", 32'(bus.Ready1), 32'h0);
        tick();
        applyStimulus(1'b0, 16'h0, 1'b1, 16'hB777, 1'b1, 1'b0);
        checkOutput("flush busy", 32'(bus.Busy), 32'h1);
        nOut = 0;
        done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            if (!bus.Busy) begin
                done = 1'b1;
            end else begin
                checkOutput($sformatf("flush ready1 c%0d", c), 32'(bus.Ready1), 32'h0);
                if (bus.OutValid) begin
                    if (nOut < 3) begin
                        checkOutput($sformatf("flush dout %0d", nOut), 32'(bus.Dout), 32'h3000 + 32'(nOut));
                    end
                    nOut++;
                end
                tick();
            end
        end
        applyStimulus(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0);
        checkOutput("flush reached idle", 32'(done), 32'h1);
        checkOutput("flush drained words", 32'(nOut), 32'h3);
        checkOutput("flush count end", 32'(bus.Count), 32'h0);

        // Flush while idle blocks acceptance for that cycle.
        applyStimulus(1'b1, 16'h5555, 1'b0, 16'h0, 1'b1, 1'b1);
        checkOutput("idle flush ready0", 32'(bus.Ready0), 32'h0);
        tick();
        applyStimulus(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0);
        checkOutput("idle flush busy", 32'(bus.Busy), 32'h0);
        checkOutput("idle flush count", 32'(bus.Count), 32'h0);

        // Asynchronous reset with five words held in the chain.
        resetDut();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 16'h9000 + 16'(i), 1'b0, 16'h0, 1'b0, 1'b0);
            tick();
        end
        applyStimulus(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
        checkOutput("pre-reset count", 32'(bus.Count), 32'h5);
        #2;
        Reset = 1'b0;
        #1;
        checkOutput("async reset count", 32'(bus.Count), 32'h0);
        checkOutput("async reset busy", 32'(bus.Busy), 32'h0);
        checkOutput("async reset outvalid", 32'(bus.OutValid), 32'h0);
        checkOutput("async reset dout", 32'(bus.Dout), 32'h0);
        #2;
        Reset = 1'b1;
        applyStimulus(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0);
        seen = 0;
        repeat (12) begin
            tick();
            if (bus.OutValid) seen++;
        end
        checkOutput("post-reset words emitted", 32'(seen), 32'h0);
        checkOutput("post-reset count", 32'(bus.Count), 32'h0);

`ifdef SHREG_ARB_STATS_EN
        // Accept counters, including saturation of requester 0.
        resetDut();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 16'h0, 1'b1, 16'hC000, 1'b1, 1'b0);
            tick();
        end
        applyStimulus(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0);
        checkOutput("stats acc1", 32'(bus.Acc1), 32'h3);
        checkOutput("stats acc0", 32'(bus.Acc0), 32'h0);
        repeat (65535) begin
            applyStimulus(1'b1, 16'h0001, 1'b0, 16'h0, 1'b1, 1'b0);
            tick();
        end
        checkOutput("stats acc0 full", 32'(bus.Acc0), 32'hFFFF);
        applyStimulus(1'b1, 16'h0002, 1'b0, 16'h0, 1'b1, 1'b0);
        checkOutput("stats extra ready0", 32'(bus.Ready0), 32'h1);
        tick();
        applyStimulus(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0);
        checkOutput("stats acc0 saturated", 32'(bus.Acc0), 32'hFFFF);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
